// File: rtl/rr_grant_pkg.sv
// rtl/rr_grant_pkg.sv - shared types and helpers for the round-robin grant controller
package rr_grant_pkg;

    localparam int N_REQ = 4;
    localparam int ID_W  = 2;

    typedef logic [N_REQ-1:0] req_vec_t;

    // Arbitration state is carried entirely by the registered owner_vld flag.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } arb_state_t;

    // Index of the set bit in a one-hot vector; zero for an all-zero vector.
    function automatic logic [ID_W-1:0] onehot_to_idx(input req_vec_t vec);
        logic [ID_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (vec[i]) begin
                idx = i[ID_W-1:0];
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_grant_ctrl_rr_pick.sv
// rtl/rr_grant_ctrl_rr_pick.sv - rotate-priority picker: first set bit after the last winner
module rr_pick
    import rr_grant_pkg::*;
(
    input  logic [N_REQ-1:0] mask,
    input  logic [ID_W-1:0]  last,
    output logic [N_REQ-1:0] pick
);

    logic [ID_W-1:0] idx;
    logic            found;

    // Scan last+1, last+2, ... wrapping; the 2-bit add wraps modulo 4 by itself.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = '0;
        for (int d = 1; d <= N_REQ; d++) begin
            idx = last + d[ID_W-1:0];
            if (!found && mask[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_grant_ctrl.sv
// rtl/rr_grant_ctrl.sv - four-requester round-robin arbiter with bounded tenure
module rr_grant_ctrl
    import rr_grant_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 8
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       req,
    output logic [3:0]       gnt,
    output logic             owner_vld,
    output logic [1:0]       owner_id,
    output logic [CNT_W-1:0] tenure,
    output logic             handover
);

    arb_state_t      state;
    logic [ID_W-1:0] ptr;
    req_vec_t        owner_oh;
    req_vec_t        others;
    req_vec_t        pick_mask;
    logic [ID_W-1:0] pick_last;
    req_vec_t        pick_gnt;
    logic            keep;
    logic            expired;
    logic            gnt_any;
    logic [ID_W-1:0] gnt_idx;
    logic            same_owner;

    assign owner_oh   = req_vec_t'(1) << owner_id;
    assign others     = req & ~owner_oh;
    assign expired    = (tenure == CNT_W'(MAX_HOLD - 1));
    assign gnt_any    = |gnt;
    assign gnt_idx    = onehot_to_idx(gnt);
    assign same_owner = owner_vld && (gnt_idx == owner_id);

    // One picker serves both states: the owner is masked out and used as the rotation origin when owned.
    rr_pick u_pick (
        .mask (pick_mask),
        .last (pick_last),
        .pick (pick_gnt)
    );

    // State decode, picker inputs and the combinational grant; reset forces the grant off at once.
    always_comb begin
        state     = owner_vld ? ST_OWNED : ST_IDLE;
        pick_mask = req;
        pick_last = ptr;
        keep      = 1'b0;
        case (state)
            ST_IDLE: begin
                pick_mask = req;
                pick_last = ptr;
            end
            ST_OWNED: begin
                pick_mask = others;
                pick_last = owner_id;
                keep      = req[owner_id] && !(expired && (|others));
            end
            default: begin
                keep = 1'b0;
            end
        endcase
        if (!rst_n) begin
            gnt = '0;
        end else if (keep) begin
            gnt = owner_oh;
        end else begin
            gnt = pick_gnt;
        end
    end

    // Ownership, rotation pointer, saturating tenure and handover pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_vld <= 1'b0;
            owner_id  <= '0;
            ptr       <= 2'd3;
            tenure    <= '0;
            handover  <= 1'b0;
        end else begin
            owner_vld <= gnt_any;
            if (gnt_any) begin
                owner_id <= gnt_idx;
                ptr      <= gnt_idx;
            end
            if (gnt_any && same_owner) begin
                tenure <= expired ? tenure : tenure + CNT_W'(1);
            end else begin
                tenure <= '0;
            end
            handover <= gnt_any && !same_owner;
        end
    end

endmodule

// File: tb/tb_rr_grant_ctrl.sv
// tb/tb_rr_grant_ctrl.sv - scoreboard bench for rr_grant_ctrl at MAX_HOLD 1, 3 and 8
module tb_rr_grant_ctrl;

    typedef logic [2:0][3:0] gvec_t;
    typedef struct packed {
        logic [2:0]      vld;
        logic [2:0][1:0] oid;
        logic [2:0][7:0] ten;
        logic [2:0]      ho;
    } rexp_t;

    logic            clk;
    logic            rst_n;
    logic [3:0]      req;
    gvec_t           gnt_a;
    logic [2:0]      vld_a;
    logic [2:0][1:0] oid_a;
    logic [2:0][7:0] ten_a;
    logic [2:0]      ho_a;

    gvec_t q_gnt[$];
    rexp_t q_reg[$];
    bit    mon_en;
    int    compared;
    int    mismatched;

    int         m_own  [3];
    int         m_held [3];
    int         m_last [3];
    logic [1:0] m_oid  [3];
    int         wt     [3][4];

    function automatic int mh(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 3 : 8);
    endfunction

    for (genvar k = 0; k < 3; k++) begin : g_dut
        rr_grant_ctrl #(.MAX_HOLD(mh(k)), .CNT_W(8)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .req       (req),
            .gnt       (gnt_a[k]),
            .owner_vld (vld_a[k]),
            .owner_id  (oid_a[k]),
            .tenure    (ten_a[k]),
            .handover  (ho_a[k])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int k, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s inst%0d (MAX_HOLD=%0d) t=%0t: got %0h expected %0h", name, k, mh(k), $time, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_own[k]  = -1;
            m_held[k] = 0;
            m_last[k] = 3;
            m_oid[k]  = 2'd0;
            for (int i = 0; i < 4; i++) wt[k][i] = 0;
        end
    endtask

    // Grant rule: the owner stays unless it dropped, or its hold budget is spent while someone else waits.
    function automatic logic [3:0] model_gnt(input int k, input logic [3:0] r);
        logic [3:0] mask;
        int         own;
        int         idx;
        own  = m_own[k];
        mask = r;
        if (own >= 0) begin
            mask = r & ~(4'b0001 << own);
            if (r[own] && !(m_held[k] >= mh(k) && mask != 4'b0000)) return 4'b0001 << own;
        end
        for (int d = 1; d <= 4; d++) begin
            idx = (m_last[k] + d) % 4;
            if (mask[idx]) return 4'b0001 << idx;
        end
        return 4'b0000;
    endfunction

    task automatic run_cycle(input logic [3:0] r);
        gvec_t g;
        rexp_t e;
        int    idx;
        req = r;
        for (int k = 0; k < 3; k++) g[k] = model_gnt(k, r);
        q_gnt.push_back(g);
        for (int k = 0; k < 3; k++) begin
            if (g[k] == 4'b0000) begin
                m_own[k]  = -1;
                m_held[k] = 0;
                e.vld[k]  = 1'b0;
                e.ho[k]   = 1'b0;
                e.ten[k]  = 8'd0;
            end else begin
                idx = 0;
                for (int i = 0; i < 4; i++) if (g[k][i]) idx = i;
                e.ho[k]  = (idx != m_own[k]);
                if (idx != m_own[k]) m_held[k] = 1;
                else if (m_held[k] < mh(k)) m_held[k] = m_held[k] + 1;
                m_own[k]  = idx;
                m_last[k] = idx;
                m_oid[k]  = idx[1:0];
                e.vld[k]  = 1'b1;
                e.ten[k]  = 8'(m_held[k] - 1);
            end
            e.oid[k] = m_oid[k];
        end
        q_reg.push_back(e);
        @(negedge clk);
    endtask

    // Combinational-grant monitor: sampled mid low phase, checks grant, contract and starvation bound.
    initial begin
        gvec_t g;
        bit    ok;
        forever begin
            @(negedge clk);
            #2;
            if (mon_en && q_gnt.size() > 0) begin
                g = q_gnt.pop_front();
                for (int k = 0; k < 3; k++) begin
                    check("gnt", k, 32'(gnt_a[k]), 32'(g[k]));
                    ok = $onehot0(gnt_a[k]) && ((gnt_a[k] & ~req) == 4'b0000) &&
                         (gnt_a[k] != 4'b0000 || req == 4'b0000);
                    assert (ok) else $error("contract violated inst%0d gnt=%b req=%b", k, gnt_a[k], req);
                    check("contract", k, 32'(ok), 32'd1);
                    for (int i = 0; i < 4; i++) begin
                        if (req[i] && !gnt_a[k][i]) wt[k][i]++;
                        else wt[k][i] = 0;
                        check("wait_bound", k, 32'(wt[k][i] <= 3 * mh(k)), 32'd1);
                    end
                end
            end
        end
    end

    // Registered-output monitor: sampled just after the edge the expectation was computed for.
    initial begin
        rexp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en && q_reg.size() > 0) begin
                e = q_reg.pop_front();
                for (int k = 0; k < 3; k++) begin
                    check("owner_vld", k, 32'(vld_a[k]), 32'(e.vld[k]));
                    check("owner_id", k, 32'(oid_a[k]), 32'(e.oid[k]));
                    check("tenure", k, 32'(ten_a[k]), 32'(e.ten[k]));
                    check("handover", k, 32'(ho_a[k]), 32'(e.ho[k]));
                end
            end
        end
    end

    initial begin
        logic [3:0] cur;
        compared   = 0;
        mismatched = 0;
        mon_en     = 1'b0;
        rst_n      = 1'b0;
        req        = 4'b1111;
        model_reset();

        #3;
        for (int k = 0; k < 3; k++) check("gnt_in_reset", k, 32'(gnt_a[k]), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            check("reset_vld", k, 32'(vld_a[k]), 32'd0);
            check("reset_oid", k, 32'(oid_a[k]), 32'd0);
            check("reset_ten", k, 32'(ten_a[k]), 32'd0);
            check("reset_ho", k, 32'(ho_a[k]), 32'd0);
        end
        @(negedge clk);
        req    = 4'b0000;
        rst_n  = 1'b1;
        mon_en = 1'b1;

        repeat (5)  run_cycle(4'b0000);
        repeat (40) run_cycle(4'b1111);
        repeat (20) run_cycle(4'b0001);
        repeat (2)  run_cycle(4'b0100);

        run_cycle(4'b0000);
        repeat (4) run_cycle(4'b1111);
        mon_en = 1'b0;
        check("pre_reset_tenure", 2, 32'(ten_a[2]), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            check("gnt_async_reset", k, 32'(gnt_a[k]), 32'd0);
            check("vld_async_reset", k, 32'(vld_a[k]), 32'd0);
            check("ten_async_reset", k, 32'(ten_a[k]), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        #1;
        for (int k = 0; k < 3; k++) begin
            check("gnt_after_release", k, 32'(gnt_a[k]), 32'b0001);
            check("vld_after_release", k, 32'(vld_a[k]), 32'd0);
        end
        mon_en = 1'b1;
        repeat (6) run_cycle(4'b1111);

        cur = 4'b1111;
        for (int n = 0; n < 10000; n++) begin
            if ($urandom_range(0, 3) == 0) cur = 4'($urandom_range(0, 15));
            run_cycle(cur);
        end

        @(negedge clk);
        #5;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
